pooling_sched: RTL and testbench
================================

# pooling_sched

Sequencer and output collector for the `pooling_top` array.
- On a `start` pulse it drives the diagonal, one-cycle-per-column skewed `en` pattern that matches the systolic array's output wavefront, for one `IMG_W`×`IMG_W` frame.
- It captures every pooled result (`pooling_done`/`pooling_out`) into a per-column hold register and merges all columns into a single tagged write stream using a round-robin arbiter.
- It signals `frame_done` once every column has delivered `OUT_PER_COL` results.
- Position: between the systolic array/pooling bank and the feature-map write port.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of a pooled value.
- `COL`, 32, number of pooling columns.
- `IMG_W`, 28, input frame edge; `PIX` = `IMG_W`*`IMG_W` (784).
- `POOL`, 2, pooling window edge; `OUT_PER_COL` = (`IMG_W`/`POOL`)² (196).

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `start`, in, 1, frame request; sampled only in IDLE.
- `busy`, out, 1, high in RUN and DRAIN.
- `frame_done`, out, 1, one-cycle pulse when the frame is complete.
- `en`, out, [COL], per-column enable to the pooling units.
- `pooling_done`, in, [COL], per-column result strobe.
- `pooling_out`, in, [COL]×DATA_WIDTH, per-column result value.
- `wr_valid`, out, 1, a merged result is presented.
- `wr_ready`, in, 1, the sink accepts it.
- `wr_data`, out, DATA_WIDTH, result value.
- `wr_col`, out, $clog2(COL), source column.
- `wr_idx`, out, $clog2(OUT_PER_COL), result index within the column (0..OUT_PER_COL-1).
- `overflow`, out, 1, sticky error flag; cleared only by `rst`.

## Operation
FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start`=1.
  - Clears `t`, every `out_cnt[c]`, every hold register, and the arbiter pointer. `overflow` is not cleared.
- RUN:
  - Cycle counter `t` counts 0, 1, 2, …
  - `en[c]` = 1 exactly when `c` ≤ `t` ≤ `c`+`PIX`-1.
  - RUN → DRAIN after the cycle with `t` = `COL`+`PIX`-2, which is the last cycle of `en[COL-1]`.
- DRAIN → DONE when every `out_cnt[c]` = `OUT_PER_COL` and all hold registers are empty.
- DONE lasts one cycle, with `frame_done`=1, then returns to IDLE.
- `start` outside IDLE is ignored.

Capture and arbitration, active in RUN and DRAIN:
- `pooling_done[c]` is accepted when hold[c] is empty, or is being granted in the same cycle.
  - Stores `pooling_out[c]` and `out_cnt[c]`, then increments `out_cnt[c]`.
- `pooling_done[c]` while hold[c] is full and not granted: the sample is dropped, `overflow` is set, and `out_cnt[c]` is unchanged.
- `pooling_done[c]` when `out_cnt[c]` = `OUT_PER_COL`: the sample is dropped and `overflow` is set.
- `pooling_done` in IDLE or DONE is ignored.
- Arbiter:
  - Grants the first full hold register at or after pointer `ptr`, in increasing index order with wrap-around.
  - `wr_valid` = any hold register full.
  - `wr_data`, `wr_col`, `wr_idx` come from the granted entry.
  - On `wr_valid`&`wr_ready`, the granted hold register empties and `ptr` ← grant+1 mod `COL`.
  - When no handshake occurs, `ptr` holds.
- `wr_*` outputs stay stable while `wr_valid`=1 and `wr_ready`=0, unless a lower-ranked entry fills; the grant may change then. The sink must tolerate this.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `en`=0, `busy`=0, `frame_done`=0, `wr_valid`=0, `wr_data`=0, `wr_col`=0, `wr_idx`=0, `overflow`=0.
  - `t`=0, `ptr`=0, all `out_cnt`=0, all hold registers empty.
- Reset during RUN or DRAIN aborts the frame. `en` drops to 0 asynchronously. No `frame_done`.
- `start` sampled high at edge k:
  - `busy`=1 and `en[0]`=1 from cycle k+1.
  - `en[c]` rises at cycle k+1+c and stays high for `PIX` cycles.
- `en` and `busy` are registered outputs, decoded from the state and `t` registers with no input-to-output combinational path.
- Capture latency: `pooling_done[c]` high at edge m → `wr_valid` high in cycle m+1, provided the arbiter grants column c.
- `wr_*` outputs are combinational from the hold registers and `ptr`; there is no path from `wr_ready` to `wr_valid`.
- `frame_done` rises one cycle after the DRAIN exit condition holds. `busy` is 0 during DONE.
- Sustained throughput: one result per cycle with `wr_ready`=1.

## Structure
- `pooling_pkg` holds:
  - the `sched_state_t` enum (IDLE, RUN, DRAIN, DONE);
  - the default `DATA_WIDTH`, `COL`, `IMG_W`, `POOL`;
  - derived localparams `PIX`, `OUT_PER_COL`, `T_LAST` (`COL`+`PIX`-2);
  - width constants for `t`, `wr_col`, `wr_idx`.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - inputs: request vector, `ptr`;
  - outputs: one-hot grant, encoded grant index, `any`.
- The FSM, counters, and hold registers live in `pooling_sched`.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 immediately. Release `rst` and hold `start`=0 for 10 cycles → `busy`=0, `en`=0.
- **Skew:** bench parameters `COL`=4, `IMG_W`=4, `POOL`=2; `start` at edge k.
  - `en[0]` high for cycles k+1..k+16; `en[3]` high for cycles k+4..k+19.
  - DRAIN entered after cycle k+19.
- **Full frame:** same parameters; each column strobes `pooling_done` 4 times with distinct values; `wr_ready`=1.
  - Exactly 16 writes; each column produces `wr_idx` 0,1,2,3 in order.
  - `frame_done` is a single pulse after the last write; `overflow`=0.
- **Round robin:** all 4 columns strobe on the same edge, `ptr`=0, `wr_ready`=1.
  - `wr_col` = 0,1,2,3 on consecutive cycles.
  - Next simultaneous burst starts from `ptr`=0 again (wrapped). With `ptr`=2 the order is 2,3,0,1.
- **Overflow:** `wr_ready`=0; column 1 strobes twice → second value dropped, `overflow`=1, `out_cnt[1]`=1.
  - Repeat with `wr_ready`=1 on the second strobe cycle → both accepted, `overflow` stays 0.
- **Ignored / abort:** `start` pulsed during RUN → no restart; `t` continues. A fifth strobe on a column → `overflow`=1.
  - `rst` in DRAIN → `en`=0, no `frame_done`. A new `start` then runs a clean frame.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared types and default geometry for the pooling scheduler slice.
package pooling_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COL         = 32;
    localparam int DEF_IMG_W       = 28;
    localparam int DEF_POOL        = 2;

    localparam int DEF_PIX         = DEF_IMG_W * DEF_IMG_W;
    localparam int DEF_OUT_PER_COL = (DEF_IMG_W / DEF_POOL) * (DEF_IMG_W / DEF_POOL);
    localparam int DEF_T_LAST      = DEF_COL + DEF_PIX - 2;

    localparam int DEF_T_W         = $clog2(DEF_T_LAST + 1);
    localparam int DEF_COL_W       = $clog2(DEF_COL);
    localparam int DEF_IDX_W       = $clog2(DEF_OUT_PER_COL);

endpackage

// File: rtl/pooling_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping, with one-hot and encoded grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (!any && req[pos[IW-1:0]]) begin
                any                 = 1'b1;
                gnt[pos[IW-1:0]]    = 1'b1;
                gnt_idx             = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pooling_sched.sv
// Frame sequencer for the pooling array: skewed column enables, per-column result
// capture and a round-robin merge of all columns into one tagged write stream.
module pooling_sched import pooling_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COL        = DEF_COL,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int POOL       = DEF_POOL
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         frame_done,
    output logic [COL-1:0]                               en,
    input  logic [COL-1:0]                               pooling_done,
    input  logic [COL-1:0][DATA_WIDTH-1:0]               pooling_out,
    output logic                                         wr_valid,
    input  logic                                         wr_ready,
    output logic [DATA_WIDTH-1:0]                        wr_data,
    output logic [$clog2(COL)-1:0]                       wr_col,
    output logic [$clog2((IMG_W/POOL)*(IMG_W/POOL))-1:0] wr_idx,
    output logic                                         overflow
);

    localparam int PIX         = IMG_W * IMG_W;
    localparam int OUT_PER_COL = (IMG_W / POOL) * (IMG_W / POOL);
    localparam int T_LAST      = COL + PIX - 2;
    localparam int TW          = $clog2(T_LAST + 1);
    localparam int CW          = $clog2(COL);
    localparam int XW          = $clog2(OUT_PER_COL);
    localparam int NW          = $clog2(OUT_PER_COL + 1);

    sched_state_t                   state_q, state_d;
    logic [TW-1:0]                  t_q, t_d;
    logic [CW-1:0]                  ptr_q, ptr_d;
    logic [COL-1:0]                 full_q, full_d;
    logic [COL-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [COL-1:0][XW-1:0]         idx_q, idx_d;
    logic [COL-1:0][NW-1:0]         cnt_q, cnt_d;
    logic                           ovf_q, ovf_d;

    logic [COL-1:0] gnt;
    logic [CW-1:0]  gnt_idx;
    logic           any;
    logic           hs;
    logic           all_done;

    rr_arbiter #(.N(COL)) u_arb (
        .req     (full_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign hs         = any & wr_ready;
    assign wr_valid   = any;
    assign wr_col     = gnt_idx;
    assign wr_data    = any ? data_q[gnt_idx] : '0;
    assign wr_idx     = any ? idx_q[gnt_idx]  : '0;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign frame_done = (state_q == DONE);
    assign overflow   = ovf_q;

    // Column c sees its enable window shifted by c cycles from the frame start.
    always_comb begin
        en = '0;
        for (int c = 0; c < COL; c++)
            en[c] = (state_q == RUN) && (int'(t_q) >= c) && (int'(t_q) <= c + PIX - 1);
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        ptr_d    = ptr_q;
        full_d   = full_q;
        data_d   = data_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        all_done = 1'b1;
        for (int c = 0; c < COL; c++)
            if ((int'(cnt_q[c]) != OUT_PER_COL) || full_q[c]) all_done = 1'b0;

        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                t_d     = '0;
                ptr_d   = '0;
                full_d  = '0;
                data_d  = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
            RUN: begin
                if (t_q == TW'(T_LAST)) state_d = DRAIN;
                else                    t_d     = t_q + 1'b1;
            end
            DRAIN: if (all_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (busy) begin
            if (hs) begin
                full_d[gnt_idx] = 1'b0;
                ptr_d = (int'(gnt_idx) == COL - 1) ? '0 : gnt_idx + 1'b1;
            end
            // A full slot may refill in the same cycle it is being drained.
            for (int c = 0; c < COL; c++) begin
                if (pooling_done[c]) begin
                    if ((int'(cnt_q[c]) < OUT_PER_COL) && (!full_q[c] || (hs && gnt[c]))) begin
                        full_d[c] = 1'b1;
                        data_d[c] = pooling_out[c];
                        idx_d[c]  = cnt_q[c][XW-1:0];
                        cnt_d[c]  = cnt_q[c] + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            ptr_q   <= '0;
            full_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pooling_sched.sv
// Randomised and directed bench for pooling_sched against a cycle-level behavioural model.
module tb_pooling_sched;

    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int IW  = 4;
    localparam int PL  = 2;
    localparam int PIX = IW * IW;
    localparam int OPC = (IW / PL) * (IW / PL);
    localparam int TL  = NC + PIX - 2;
    localparam int CW  = $clog2(NC);
    localparam int XW  = $clog2(OPC);
    localparam logic [DW-1:0] VAL_A = 16'h8A5A;
    localparam logic [DW-1:0] VAL_B = 16'h8B5B;

    logic                   clk = 1'b0;
    logic                   rst, start, busy, frame_done, wr_valid, wr_ready, overflow;
    logic [NC-1:0]          en, pooling_done;
    logic [NC-1:0][DW-1:0]  pooling_out;
    logic [DW-1:0]          wr_data;
    logic [CW-1:0]          wr_col;
    logic [XW-1:0]          wr_idx;

    always #5 clk = ~clk;

    pooling_sched #(.DATA_WIDTH(DW), .COL(NC), .IMG_W(IW), .POOL(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .en(en), .pooling_done(pooling_done), .pooling_out(pooling_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_col(wr_col), .wr_idx(wr_idx), .overflow(overflow)
    );

    int vecs = 0, errs = 0;

    // model: phase 0 idle, 1 run, 2 drain, 3 done; m_t = cycles since the frame began
    int            m_phase, m_t, m_ptr;
    bit            m_ovf;
    bit            m_full[NC];
    logic [DW-1:0] m_data[NC];
    int            m_idx[NC], m_cnt[NC];

    int            sc, nwr, fd_cnt, fd_sc, last_wr_sc, exp_next[NC], seq[$];
    bit            saw_b, ovf_rdy;
    logic [DW-1:0] first_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_t = 0; m_ptr = 0; m_ovf = 0;
        for (int c = 0; c < NC; c++) begin
            m_full[c] = 0; m_data[c] = '0; m_idx[c] = 0; m_cnt[c] = 0; exp_next[c] = 0;
        end
    endtask

    function automatic int m_grant();
        for (int i = 0; i < NC; i++)
            if (m_full[(m_ptr + i) % NC]) return (m_ptr + i) % NC;
        return -1;
    endfunction

    function automatic int seq_code(input int s);
        if (seq.size() < s + 4) return 'hFFFF;
        return (seq[s] << 12) | (seq[s+1] << 8) | (seq[s+2] << 4) | seq[s+3];
    endfunction

    task automatic check_outputs();
        int g;
        logic [NC-1:0] ee;
        g = m_grant();
        for (int c = 0; c < NC; c++) ee[c] = (m_phase == 1) && (m_t >= c) && (m_t <= c + PIX - 1);
        chk("busy", busy, (m_phase == 1) || (m_phase == 2));
        chk("frame_done", frame_done, m_phase == 3);
        chk("en", en, ee);
        chk("wr_valid", wr_valid, g >= 0);
        chk("wr_data", wr_data, g >= 0 ? m_data[g] : 0);
        chk("wr_col", wr_col, g >= 0 ? g : 0);
        chk("wr_idx", wr_idx, g >= 0 ? m_idx[g] : 0);
        chk("overflow", overflow, m_ovf);
        if (frame_done) begin fd_cnt++; fd_sc = sc; end
        if (wr_valid && wr_ready) begin
            chk("idx_order", wr_idx, exp_next[wr_col]);
            exp_next[wr_col]++;
            if (nwr == 0) first_data = wr_data;
            if (wr_data == VAL_B) saw_b = 1;
            nwr++; last_wr_sc = sc; seq.push_back(int'(wr_col));
        end
    endtask

    task automatic model_step();
        int g;
        bit hs, alldone;
        bit full0[NC];
        sc++;
        if (rst) begin m_reset(); return; end
        g = m_grant(); hs = (g >= 0) && wr_ready; full0 = m_full;
        case (m_phase)
            0: if (start) begin
                m_reset(); m_phase = 1; m_ovf = overflow;
            end
            1, 2: begin
                alldone = 1;
                for (int c = 0; c < NC; c++) if (m_cnt[c] != OPC || full0[c]) alldone = 0;
                if (hs) begin m_full[g] = 0; m_ptr = (g + 1) % NC; end
                for (int c = 0; c < NC; c++) if (pooling_done[c]) begin
                    if (m_cnt[c] < OPC && (!full0[c] || (hs && g == c))) begin
                        m_full[c] = 1; m_data[c] = pooling_out[c]; m_idx[c] = m_cnt[c]; m_cnt[c]++;
                    end else m_ovf = 1;
                end
                if (m_phase == 1) begin if (m_t == TL) m_phase = 2; else m_t++; end
                else if (alldone) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(negedge clk); check_outputs(); model_step();
        @(posedge clk); #1;
    endtask

    task automatic rnd_drive();
        if (m_phase == 1) begin
            for (int c = 0; c < NC; c++) pooling_done[c] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) start = 1;
        end else if (m_phase == 2)
            for (int c = 0; c < NC; c++) pooling_done[c] = (m_cnt[c] < OPC) && ($urandom_range(0, 1) == 1);
        wr_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input int mode);
        pooling_done = '0; start = 0; wr_ready = 1;
        for (int c = 0; c < NC; c++) pooling_out[c] = DW'($urandom_range(0, 16'h7FFF));
        case (mode)
            0, 4: if (m_phase == 1) begin
                if ((m_t % 4) == 2 && m_t <= 14) pooling_done = '1;
                if (mode == 4 && m_t == 5)  start = 1;
                if (mode == 4 && m_t == 17) pooling_done[2] = 1;
            end
            2: if (m_phase == 1) begin
                if (m_t == 1) pooling_done[1] = 1;
                else if (m_t == 3 || m_t == 7 || m_t == 11) pooling_done = '1;
                else if (m_t == 15) pooling_done = 4'b1101;
            end
            3: if (m_phase == 1 && m_t <= 4) begin
                wr_ready = (m_t == 4);
                if (m_t == 1) begin pooling_done[1] = 1; pooling_out[1] = VAL_A; end
                if (m_t == 2) begin pooling_done[1] = 1; pooling_out[1] = VAL_B; wr_ready = ovf_rdy; end
                if (m_t == 3) chk("ovf_directed", overflow, !ovf_rdy);
            end else rnd_drive();
            default: rnd_drive();
        endcase
    endtask

    task automatic pin_skew();
        case (sc)
            1:  begin chk("skew_busy_k1", busy, 1); chk("skew_en0_k1", en[0], 1); end
            3:  chk("skew_en3_k3", en[3], 0);
            4:  chk("skew_en3_k4", en[3], 1);
            16: chk("skew_en0_k16", en[0], 1);
            17: chk("skew_en0_k17", en[0], 0);
            19: chk("skew_en3_k19", en[3], 1);
            20: begin chk("skew_en_k20", en, 0); chk("skew_busy_k20", busy, 1); end
            default: ;
        endcase
    endtask

    task automatic run_frame(input int mode, input bit pin, input bit abort);
        int budget;
        budget = 600;
        sc = 0; nwr = 0; fd_cnt = 0; fd_sc = 0; last_wr_sc = 0; saw_b = 0; seq.delete();
        pooling_done = '0; wr_ready = 1; start = 1;
        tick();
        start = 0;
        while (m_phase != 0 && budget > 0 && !(abort && m_phase == 2)) begin
            if (pin) pin_skew();
            drive(mode); tick(); budget--;
        end
        pooling_done = '0; start = 0;
        chk("frame_timeout", budget == 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; #1; m_reset(); tick(); rst = 0;
    endtask

    initial begin
        rst = 1; start = 0; pooling_done = '0; pooling_out = '0; wr_ready = 0; ovf_rdy = 0;
        m_reset();
        #1;
        chk("rst_busy", busy, 0); chk("rst_en", en, 0); chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_data", wr_data, 0); chk("rst_ovf", overflow, 0); chk("rst_fd", frame_done, 0);
        repeat (2) tick();
        rst = 0;
        repeat (10) tick();
        chk("idle_busy", busy, 0); chk("idle_en", en, 0);

        run_frame(0, 1, 0);
        chk("f1_writes", nwr, 16); chk("f1_done_pulses", fd_cnt, 1);
        chk("f1_done_after_wr", fd_sc > last_wr_sc, 1); chk("f1_ovf", overflow, 0);
        chk("rr_burst0", seq_code(0), 'h0123); chk("rr_burst1", seq_code(4), 'h0123);

        run_frame(2, 0, 0);
        chk("rr_single", seq.size() > 0 ? seq[0] : -1, 1);
        chk("rr_ptr2", seq_code(1), 'h2301); chk("f2_writes", nwr, 16);

        ovf_rdy = 0;
        run_frame(3, 0, 0);
        chk("ovf_first_col", seq.size() > 0 ? seq[0] : -1, 1);
        chk("ovf_first_data", first_data, VAL_A);
        chk("ovf_b_dropped", saw_b, 0); chk("ovf_sticky", overflow, 1);

        // mid-cycle asynchronous reset during RUN
        start = 1; tick(); start = 0;
        repeat (5) begin drive(1); tick(); end
        #2 rst = 1; #1;
        chk("arst_en", en, 0); chk("arst_busy", busy, 0); chk("arst_wr_valid", wr_valid, 0);
        chk("arst_wr_col", wr_col, 0); chk("arst_wr_idx", wr_idx, 0); chk("arst_ovf", overflow, 0);
        m_reset(); pooling_done = '0; tick(); rst = 0;

        ovf_rdy = 1;
        run_frame(3, 0, 0);
        chk("ovf_both_kept", saw_b, 1);
        chk("ovf_rdy_first_data", first_data, VAL_A);

        do_reset();
        run_frame(4, 0, 0);
        chk("fifth_strobe_ovf", overflow, 1); chk("f4_writes", nwr, 16); chk("f4_done", fd_cnt, 1);

        run_frame(0, 0, 1);
        chk("abort_in_drain", m_phase, 2);
        rst = 1; #1;
        chk("abort_en", en, 0); chk("abort_busy", busy, 0);
        m_reset(); tick(); rst = 0;
        repeat (5) tick();
        chk("abort_no_done", fd_cnt, 0);

        run_frame(0, 0, 0);
        chk("clean_writes", nwr, 16); chk("clean_done", fd_cnt, 1); chk("clean_ovf", overflow, 0);

        repeat (4) run_frame(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
